// File: rtl/ram_regiones.sv
// Single-port data RAM with a write-protected upper region, one-cycle registered
// read, and a clear sequencer that zeroes every word after reset.
module ram_regiones #(
  parameter int ANCHO   = 32,
  parameter int AW      = 5,
  parameter int LIM_ESC = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    DirRam,
  input  logic [ANCHO-1:0] DatosE,
  input  logic             WE,
  input  logic             RE,
  output logic [ANCHO-1:0] DatosS,
  output logic             Valido,
  output logic             Listo,
  output logic             ErrEsc
);

  localparam int PROF = 2**AW;
  // One extra bit so that a limit of 2**AW (everything writable) is representable.
  localparam logic [AW:0] LIM_W = (AW+1)'(LIM_ESC);

  typedef enum logic [0:0] {
    LIMPIA = 1'b0,
    LISTO  = 1'b1
  } estado_t;

  estado_t          estado_r;
  logic [AW-1:0]    cont_r;
  logic [ANCHO-1:0] mem_r [PROF];

  logic             permitido_s;
  logic             we_s;
  logic [AW-1:0]    wa_s;
  logic [ANCHO-1:0] wd_s;

  assign permitido_s = ({1'b0, DirRam} < LIM_W);

  // Memory write port mux: clear sequencer owns the port until LISTO.
  always_comb begin
    we_s = 1'b0;
    wa_s = DirRam;
    wd_s = DatosE;
    if (rst) begin
      we_s = 1'b0;
    end else if (estado_r == LIMPIA) begin
      we_s = 1'b1;
      wa_s = cont_r;
      wd_s = '0;
    end else if (WE && permitido_s) begin
      we_s = 1'b1;
    end else begin
      we_s = 1'b0;
    end
  end

  // Storage array; no reset, contents are zeroed by the clear sequence.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_r[wa_s] <= wd_s;
    end
  end

  // Sequencer state, clear counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_r <= LIMPIA;
      cont_r   <= '0;
      DatosS   <= '0;
      Valido   <= 1'b0;
      Listo    <= 1'b0;
      ErrEsc   <= 1'b0;
    end else begin
      case (estado_r)
        LIMPIA: begin
          cont_r <= cont_r + AW'(1);
          Valido <= 1'b0;
          ErrEsc <= 1'b0;
          if (cont_r == {AW{1'b1}}) begin
            estado_r <= LISTO;
            Listo    <= 1'b1;
          end
        end
        LISTO: begin
          // Read sees the pre-write contents when WE and RE hit the same word.
          ErrEsc <= WE && !permitido_s;
          Valido <= RE;
          if (RE) begin
            DatosS <= mem_r[DirRam];
          end
        end
        default: begin
          estado_r <= LIMPIA;
          cont_r   <= '0;
          Listo    <= 1'b0;
          Valido   <= 1'b0;
          ErrEsc   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ram_regiones.md
# ram_regiones

Parametrised single-port data RAM with a write-protected upper region, registered read, and a power-up clear sequencer. It replaces the fixed 32x32 combinational data RAM in the datapath: the ALU result path writes through it, and the register/load path reads from it. Only addresses below a configurable limit accept writes; writes above it are dropped and flagged. Read latency is exactly one clock.

## Interface
- ANCHO, 32: data word width in bits (>=1)
- AW, 5: address width; depth = 2**AW words
- LIM_ESC, 8: number of writable words; addresses 0..LIM_ESC-1 writable, LIM_ESC..2**AW-1 read-only; legal range 0..2**AW

- clk  in  1  rising-edge clock, single clock domain
- rst  in  1  synchronous reset, active-high
- DirRam  in  AW  word address for read and write
- DatosE  in  ANCHO  write data
- WE  in  1  write enable
- RE  in  1  read enable
- DatosS  out  ANCHO  registered read data
- Valido  out  1  DatosS updated by a read this cycle (one-cycle pulse)
- Listo  out  1  clear sequence complete; RAM accepts accesses
- ErrEsc  out  1  one-cycle pulse: rejected write to protected address

## Operation
- Reset: synchronous, active-high; sampled at rising edge of clk.
- States: LIMPIA, LISTO.
- While rst=1 at an edge: state <= LIMPIA, clear counter <= 0, DatosS <= 0, Valido <= 0, Listo <= 0, ErrEsc <= 0. No memory write on that edge.
- LIMPIA (rst=0): each edge writes 0 to mem[counter], counter increments. On the edge writing address 2**AW-1: state <= LISTO, Listo <= 1. WE/RE ignored in LIMPIA; no ErrEsc, no Valido, DatosS stays 0.
- Reset asserted mid-clear: counter returns to 0; full clear restarts after release.
- LISTO:
  - WE=1 and DirRam < LIM_ESC: mem[DirRam] <= DatosE at the edge.
  - WE=1 and DirRam >= LIM_ESC: memory unchanged; ErrEsc <= 1 for exactly that following cycle.
  - RE=1: DatosS <= mem[DirRam]; Valido <= 1. RE=0: DatosS holds its last value; Valido <= 0.
  - WE=1 and RE=1 same edge, same address: read-before-write; DatosS gets the old contents; the write still takes effect.
  - ErrEsc and Valido are independent; both may be 1 in the same cycle.
- LISTO is left only by reset.
- Comparisons are unsigned on AW bits. LIM_ESC=0: every write is rejected. LIM_ESC=2**AW: no write is rejected; ErrEsc never asserts.

## Timing
- Clear duration: Listo rises 2**AW cycles after the first edge with rst=0 (32 cycles at defaults).
- Read latency: 1 cycle. Address and RE are sampled at edge N; DatosS and Valido are valid after edge N. Valido falls at edge N+1 unless RE is still high.
- Write: takes effect at the sampling edge. A read of the same address at edge N+1 returns the new value.
- ErrEsc: asserted after the sampling edge of the rejected write. Back-to-back rejected writes keep it high continuously.
- Outputs are all registered; no combinational path from inputs to outputs.

## Test plan
- Reset and clear: hold rst for 3 cycles, release. Expect Listo=0 for 32 cycles, then 1. Then read every address 0..31: DatosS=0, Valido=1 each cycle.
- Write/read in the allowed region: write 0xDEADBEEF to address 3. At the next edge, read address 3. Expect DatosS=0xDEADBEEF and Valido=1 one cycle later.
- Protected write: write 0x12345678 to address 8. Expect ErrEsc=1 for one cycle. A read of address 8 returns 0.
- Read-before-write: with mem[5]=0x11, assert WE=1, RE=1, address 5, DatosE=0x22. Expect DatosS=0x11. A following read returns 0x22.
- Reset mid-clear: assert rst at clear cycle 10 and release. Expect Listo only 32 cycles after release. Accesses during LIMPIA are ignored: a WE to address 1 leaves 0, and ErrEsc stays 0.
- Parameter sweep: ANCHO=8, AW=3, LIM_ESC=8. Expect Listo after 8 cycles, all writes accepted, ErrEsc never set.
